// File: rtl/ddr3_ref.sv
// DDR3 auto-refresh scheduler: counts refresh-interval ticks and, once initialisation is done,
// issues PRECHARGE-ALL + REFRESH pairs on the shared command port, postponing them while memory is busy.
module ddr3_ref #(
  parameter int DDR_ROW_BITS = 13,
  parameter int REF_POSTPONE = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_run_i,
  input  logic                    cfg_req_i,
  output logic                    cfg_rdy_o,
  input  logic [2:0]              cfg_cmd_i,
  input  logic [2:0]              cfg_ba_i,
  input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
  input  logic                    cfg_ref_i,
  input  logic                    mem_busy_i,
  output logic                    ctl_req_o,
  input  logic                    ctl_rdy_i,
  output logic [2:0]              ctl_cmd_o,
  output logic [2:0]              ctl_ba_o,
  output logic [DDR_ROW_BITS-1:0] ctl_adr_o,
  output logic                    ref_busy_o,
  output logic                    ref_urgent_o,
  output logic                    ref_err_o
);

  localparam logic [2:0] CMD_NOOP = 3'b111;
  localparam logic [2:0] CMD_PREC = 3'b010;
  localparam logic [2:0] CMD_REFR = 3'b001;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_PREA, ST_REFR} state_t;

  state_t     r_state;
  logic [3:0] r_pend;
  logic       r_ref_q;
  logic       r_err;
  logic       r_req;

  logic                    w_tick;
  logic                    w_acc;
  logic                    w_urgent;
  logic [DDR_ROW_BITS-1:0] w_a10;

  assign w_tick   = cfg_ref_i & ~r_ref_q;
  assign w_acc    = (r_state == ST_REFR) & r_req & ctl_rdy_i;
  assign w_urgent = (r_pend >= 4'(REF_POSTPONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_pend  <= '0;
      r_ref_q <= 1'b0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_ref_q <= cfg_ref_i;
      if (r_state == ST_INIT) begin
        r_pend <= '0;
        r_req  <= 1'b0;
        if (cfg_run_i) r_state <= ST_IDLE;
      end else if (!cfg_run_i) begin
        r_state <= ST_INIT;
        r_pend  <= '0;
        r_req   <= 1'b0;
      end else begin
        // a tick coinciding with a REFRESH acceptance cancels out
        if (w_tick && !w_acc) begin
          if (r_pend == 4'd8) r_err <= 1'b1;
          else                r_pend <= r_pend + 4'd1;
        end else if (!w_tick && w_acc) begin
          r_pend <= r_pend - 4'd1;
        end
        case (r_state)
          ST_IDLE: if (r_pend != 4'd0 && (!mem_busy_i || w_urgent)) begin
            r_state <= ST_PREA;
            r_req   <= 1'b1;
          end
          ST_PREA: if (r_req && ctl_rdy_i) r_state <= ST_REFR;
          ST_REFR: if (ctl_rdy_i) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_a10     = '0;
    w_a10[10] = 1'b1;
    cfg_rdy_o = 1'b0;
    ctl_req_o = r_req;
    ctl_cmd_o = CMD_NOOP;
    ctl_ba_o  = '0;
    ctl_adr_o = '0;
    case (r_state)
      ST_INIT: begin
        cfg_rdy_o = ctl_rdy_i;
        ctl_req_o = cfg_req_i;
        ctl_cmd_o = cfg_cmd_i;
        ctl_ba_o  = cfg_ba_i;
        ctl_adr_o = cfg_adr_i;
      end
      ST_PREA: begin
        ctl_cmd_o = CMD_PREC;
        ctl_adr_o = w_a10;
      end
      ST_REFR: ctl_cmd_o = CMD_REFR;
      default: ;
    endcase
  end

  assign ref_busy_o   = (r_state == ST_PREA) || (r_state == ST_REFR);
  assign ref_urgent_o = w_urgent;
  assign ref_err_o    = r_err;

endmodule
